obstacle_engine: RTL
====================

# obstacle_engine

Frame-rate obstacle manager feeding the VGA picture stage. It owns up to `NUM_OBS` rectangular obstacles and scrolls them leftward once per frame while in play. New obstacles are spawned at pseudo-random heights from an LFSR. Each frame it drives the packed `obstacle_x` / `obstacle_y` buses, a score, and a sticky player/obstacle collision flag to the game FSM.

## Interface
- `NUM_OBS`, 10, number of obstacle slots.
- `SCREEN_W`, 640, visible width; new obstacles enter at this x.
- `OBS_W`, 40, obstacle width in pixels.
- `SPEED`, 2, scroll distance in pixels per frame.
- `SPAWN_GAP`, 90, frames between spawns.
- `UPPER_BOUND`, 20, top playfield limit.
- `LOWER_BOUND`, 460, bottom playfield limit.
- `PLAYER_X`, 160, player left x.
- `PLAYER_SIZE`, 40, player square size.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame, issued by the timing stage during vertical blank.
- `gamemode`  in  2  00 initial, 01 in-game, 10 paused, 11 ended.
- `player_y`  in  9  player top y.
- `obstacle_x`  out  [NUM_OBS-1:0][19:0]  per slot {left[9:0], right[9:0]}; right is exclusive.
- `obstacle_y`  out  [NUM_OBS-1:0][17:0]  per slot {top[8:0], bottom[8:0]}; bottom is exclusive.
- `collision`  out  1  sticky player/obstacle overlap flag.
- `score`  out  16  obstacles passed, saturating.

## Operation
- **Slot encoding**
  - An inactive slot holds all fields 0. This is an empty range, so it is never drawn.
  - A slot is active iff `right != 0`.
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every clock in every mode, so player input timing adds entropy.
- **gamemode 00, every cycle (no tick needed)**
  - Clear all slots, the spawn counter, `score` and `collision`.
- **gamemode 10/11**
  - All state holds. `frame_tick` is ignored.
- **gamemode 01, on `frame_tick` only, in this order using pre-update values:**
  1. Collision (when enabled): set `collision` if any active slot satisfies all four conditions below. The flag stays 1 until mode 00.
     - `left < PLAYER_X+PLAYER_SIZE`
     - `right > PLAYER_X`
     - `top < player_y+PLAYER_SIZE`
     - `bottom > player_y`
  2. Scroll/free, for each active slot:
     - If `right <= SPEED`: free the slot (all fields 0) and increment `score`, saturating at 16'hFFFF.
     - Else: `right -= SPEED` and `left = (left > SPEED) ? left-SPEED : 0`.
  3. Spawn:
     - If the spawn counter is below `SPAWN_GAP-1`, increment it.
     - Otherwise, if any slot was inactive before this tick, spawn into the lowest-index such slot and reset the counter to 0.
     - Otherwise, hold the counter at `SPAWN_GAP-1` and retry on every later tick.
- **Spawn geometry**
  - left = `SCREEN_W`, right = `SCREEN_W+OBS_W`.
  - top = `UPPER_BOUND + lfsr[7:0] + lfsr[14:8]`.
  - bottom = min(top + 40 + 4*lfsr[3:0], `LOWER_BOUND`).
- **Widths**
  - All y arithmetic is done at 10 bits before the clamp.
  - x values stay below 1024 for the defaults.

## Timing
- All outputs are registered.
- Effects of a `frame_tick` are visible on the cycle after the tick.
- Mode-00 clearing is visible on the cycle after `gamemode` becomes 00.
- Outputs are constant between ticks, so the picture stage always sees a stable frame.
- Reset values:
  - all `obstacle_x` / `obstacle_y` = 0
  - `collision` = 0
  - `score` = 0
  - spawn counter = 0
  - LFSR = `LFSR_SEED`
- `rst_n` asserted mid-frame clears everything immediately (asynchronous). Operation restarts from the first tick after release.
- If a mode change and `frame_tick` occur in the same cycle, the new `gamemode` value governs that cycle.
- A slot freed on a tick is not reused until the next tick.

## Configuration
- `OBSTACLE_COLLISION_EN`
  - Defined: collision detection as above.
  - Undefined: the overlap logic is not built and `collision` is tied to 0.
- Scroll, spawn and score behaviour are identical with and without the macro.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs -> all outputs 0. After release in mode 01, no slot is active until the 90th tick.
- **Spawn and scroll:** mode 01, 90 ticks -> slot 0 becomes {640,680} with top ≥ 20 and bottom ≤ 460. The next tick gives {638,678}.
- **Free and score:** continue ticking -> when right reaches 2, the following tick zeroes slot 0 and `score` becomes 1.
- **Pause and mode 00:**
  - Mode 10 with 50 ticks -> outputs unchanged.
  - Mode 00 -> next cycle, all slots, `score` and `collision` are 0.
- **Collision, macro defined:** bench model sweeps `player_y` -> `collision` rises on the tick after the first overlap and stays 1 through modes 01/10/11. Undefined build -> always 0.
- **Full slots:** `SPAWN_GAP`=1, `SPEED`=1 -> 10 slots fill. The counter holds at 0 and the next spawn lands in the first slot freed, one tick after the free.

Source files
------------

// File: rtl/obstacle_engine.sv
// obstacle_engine: frame-rate obstacle scroller, LFSR spawner, scorer
// and sticky player/obstacle collision flag for the VGA picture stage.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   frame_tick    one-cycle pulse per frame (vertical blank)
//   gamemode      00 initial, 01 in-game, 10 paused, 11 ended
//   player_y      player top y
//   obstacle_x    per slot {left[9:0], right[9:0]}, right exclusive
//   obstacle_y    per slot {top[8:0], bottom[8:0]}, bottom exclusive
//   collision     sticky overlap flag
//   score         obstacles passed, saturating
//
// Build option: define OBSTACLE_COLLISION_EN to build the overlap
// logic; otherwise collision is tied to 0.

module obstacle_engine #(
    parameter int          NUM_OBS     = 10,
    parameter int          SCREEN_W    = 640,
    parameter int          OBS_W       = 40,
    parameter int          SPEED       = 2,
    parameter int          SPAWN_GAP   = 90,
    parameter int          UPPER_BOUND = 20,
    parameter int          LOWER_BOUND = 460,
    parameter int          PLAYER_X    = 160,
    parameter int          PLAYER_SIZE = 40,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    input  logic [1:0]                 gamemode,
    input  logic [8:0]                 player_y,
    output logic [NUM_OBS-1:0][19:0]   obstacle_x,
    output logic [NUM_OBS-1:0][17:0]   obstacle_y,
    output logic                       collision,
    output logic [15:0]                score
);

    localparam int CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [CW-1:0] GAP_M1 = CW'(SPAWN_GAP - 1);
    localparam logic [9:0]    SPD    = 10'(SPEED);
    localparam logic [9:0]    SX_L   = 10'(SCREEN_W);
    localparam logic [9:0]    SX_R   = 10'(SCREEN_W + OBS_W);
    localparam logic [9:0]    UB     = 10'(UPPER_BOUND);
    localparam logic [9:0]    LB     = 10'(LOWER_BOUND);

    logic [9:0] left_q  [NUM_OBS];
    logic [9:0] right_q [NUM_OBS];
    logic [8:0] top_q   [NUM_OBS];
    logic [8:0] bot_q   [NUM_OBS];
    logic [9:0] left_d  [NUM_OBS];
    logic [9:0] right_d [NUM_OBS];
    logic [8:0] top_d   [NUM_OBS];
    logic [8:0] bot_d   [NUM_OBS];

    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   score_q, score_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          fb;

    logic          clear, run;
    logic          spawn_ok, taken;
    logic [16:0]   sum;
    logic [9:0]    sp_top, sp_bot, sp_bot_raw;

    assign clear = (gamemode == 2'b00);
    assign run   = (gamemode == 2'b01) && frame_tick;

    // Fibonacci taps 16,14,13,11
    assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Spawn geometry, 10-bit before the clamp
    assign sp_top     = UB + {2'b0, lfsr_q[7:0]}
                      + {3'b0, lfsr_q[14:8]};
    assign sp_bot_raw = sp_top + 10'd40
                      + {4'b0, lfsr_q[3:0], 2'b0};
    assign sp_bot     = (sp_bot_raw > LB) ? LB : sp_bot_raw;

    always_comb begin
        left_d   = left_q;
        right_d  = right_q;
        top_d    = top_q;
        bot_d    = bot_q;
        cnt_d    = cnt_q;
        score_d  = score_q;
        lfsr_d   = {lfsr_q[14:0], fb};
        sum      = {1'b0, score_q};
        taken    = 1'b0;
        spawn_ok = (cnt_q >= GAP_M1);
        unique case (1'b1)
            clear: begin
                left_d  = '{default: '0};
                right_d = '{default: '0};
                top_d   = '{default: '0};
                bot_d   = '{default: '0};
                cnt_d   = '0;
                score_d = '0;
            end
            run: begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (right_q[i] == '0) begin
                        // first slot empty before this tick
                        if (spawn_ok && !taken) begin
                            taken      = 1'b1;
                            left_d[i]  = SX_L;
                            right_d[i] = SX_R;
                            top_d[i]   = sp_top[8:0];
                            bot_d[i]   = sp_bot[8:0];
                        end
                    end else if (right_q[i] <= SPD) begin
                        left_d[i]  = '0;
                        right_d[i] = '0;
                        top_d[i]   = '0;
                        bot_d[i]   = '0;
                        sum        = sum + 17'd1;
                    end else begin
                        right_d[i] = right_q[i] - SPD;
                        left_d[i]  = (left_q[i] > SPD) ?
                                     left_q[i] - SPD : '0;
                    end
                end
                score_d = sum[16] ? 16'hFFFF : sum[15:0];
                if (!spawn_ok)
                    cnt_d = cnt_q + 1'b1;
                else if (taken)
                    cnt_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                left_q[i]  <= '0;
                right_q[i] <= '0;
                top_q[i]   <= '0;
                bot_q[i]   <= '0;
            end
            cnt_q   <= '0;
            score_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            left_q  <= left_d;
            right_q <= right_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            lfsr_q  <= lfsr_d;
        end
    end

`ifdef OBSTACLE_COLLISION_EN
    localparam logic [9:0] PX0 = 10'(PLAYER_X);
    localparam logic [9:0] PX1 = 10'(PLAYER_X + PLAYER_SIZE);
    localparam logic [9:0] PSZ = 10'(PLAYER_SIZE);

    logic       coll_q, coll_d, hit;
    logic [9:0] py0, py1;

    assign py0 = {1'b0, player_y};
    assign py1 = py0 + PSZ;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (right_q[i] != '0
                && left_q[i] < PX1
                && right_q[i] > PX0
                && {1'b0, top_q[i]} < py1
                && {1'b0, bot_q[i]} > py0)
                hit = 1'b1;
        end
        coll_d = coll_q;
        unique case (1'b1)
            clear:   coll_d = 1'b0;
            run:     coll_d = coll_q | hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_q <= 1'b0;
        else
            coll_q <= coll_d;
    end

    assign collision = coll_q;
`else
    logic [9:0] unused_coll;
    assign unused_coll = 10'(PLAYER_X) ^ 10'(PLAYER_SIZE)
                       ^ {1'b0, player_y};
    assign collision = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_OBS; i++) begin
            obstacle_x[i] = {left_q[i], right_q[i]};
            obstacle_y[i] = {top_q[i], bot_q[i]};
        end
    end

    assign score = score_q;

endmodule
